// File: rtl/cache_burst_controller.sv
// cache_burst_controller
//   Control FSM for a write-back, line-refill cache. It looks up a load or store
//   request. It writes back a dirty victim line and refills the line word by
//   word from memory. It then replays the request. It also counts misses and
//   completed writebacks.
//
// Ports
//   clk_i        sole clock, rising edge
//   rst_i        synchronous active-high reset
//   rd_i, wr_i   LSU load / store request (held while stall_o=1; both set = store)
//   hit_i        tag match & valid for the indexed line
//   dirty_i      dirty bit of the indexed line
//   mem_ack_i    memory accepted / returned one word this cycle
//   stall_o      pipeline freeze
//   mem_req_o    word transfer request to memory
//   mem_we_o     1 = writeback word, 0 = refill read
//   word_idx_o   word offset of the current burst beat
//   data_we_o    write one word into the line (store hit or refill beat)
//   fill_sel_o   data_we_o source: 1 = memory word, 0 = LSU store data
//   tag_we_o     write tag and set valid for the indexed line
//   dirty_set_o  set the dirty bit of the indexed line
//   dirty_clr_o  clear the dirty bit of the indexed line
//   miss_cnt_o   saturating count of detected misses
//   wb_cnt_o     saturating count of completed dirty-line writebacks
module cache_burst_controller #(
  parameter  int WORDS_PER_LINE = 4,
  parameter  int CNT_W          = 16,
  localparam int IDX_W          = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             rd_i,
  input  logic             wr_i,
  input  logic             hit_i,
  input  logic             dirty_i,
  input  logic             mem_ack_i,
  output logic             stall_o,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [IDX_W-1:0] word_idx_o,
  output logic             data_we_o,
  output logic             fill_sel_o,
  output logic             tag_we_o,
  output logic             dirty_set_o,
  output logic             dirty_clr_o,
  output logic [CNT_W-1:0] miss_cnt_o,
  output logic [CNT_W-1:0] wb_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WB,
    S_FILL,
    S_UPDATE
  } state_t;

  localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(WORDS_PER_LINE - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [IDX_W-1:0] r_beat;
  logic [CNT_W-1:0] r_miss_cnt;
  logic [CNT_W-1:0] r_wb_cnt;
  logic             w_beat_clr;
  logic             w_beat_inc;
  logic             w_miss_inc;
  logic             w_wb_inc;
  logic             w_last_beat;

  assign w_last_beat = (r_beat == LAST_BEAT);

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_beat_clr   = 1'b0;
    w_beat_inc   = 1'b0;
    w_miss_inc   = 1'b0;
    w_wb_inc     = 1'b0;
    stall_o      = 1'b0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    data_we_o    = 1'b0;
    fill_sel_o   = 1'b0;
    tag_we_o     = 1'b0;
    dirty_set_o  = 1'b0;
    dirty_clr_o  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (rd_i || wr_i) begin
          stall_o      = 1'b1;
          w_next_state = S_LOOKUP;
        end
      end

      S_LOOKUP: begin
        if (hit_i) begin
          // wr_i alone decides store vs load, so rd_i&wr_i behaves as a store.
          data_we_o    = wr_i;
          dirty_set_o  = wr_i;
          w_next_state = S_IDLE;
        end else begin
          stall_o      = 1'b1;
          w_miss_inc   = 1'b1;
          w_beat_clr   = 1'b1;
          w_next_state = dirty_i ? S_WB : S_FILL;
        end
      end

      S_WB: begin
        stall_o   = 1'b1;
        mem_req_o = 1'b1;
        mem_we_o  = 1'b1;
        if (mem_ack_i) begin
          if (w_last_beat) begin
            w_beat_clr   = 1'b1;
            w_wb_inc     = 1'b1;
            w_next_state = S_FILL;
          end else begin
            w_beat_inc = 1'b1;
          end
        end
      end

      S_FILL: begin
        stall_o   = 1'b1;
        mem_req_o = 1'b1;
        if (mem_ack_i) begin
          data_we_o  = 1'b1;
          fill_sel_o = 1'b1;
          // Clearing on the last beat keeps word_idx_o at 0 outside bursts,
          // including the single-word-line case where +1 would not wrap to 0.
          if (w_last_beat) begin
            w_beat_clr   = 1'b1;
            w_next_state = S_UPDATE;
          end else begin
            w_beat_inc = 1'b1;
          end
        end
      end

      S_UPDATE: begin
        stall_o      = 1'b1;
        tag_we_o     = 1'b1;
        dirty_clr_o  = 1'b1;
        w_next_state = S_LOOKUP;
      end

      default: w_next_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_beat     <= '0;
      r_miss_cnt <= '0;
      r_wb_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_beat_clr) begin
        r_beat <= '0;
      end else if (w_beat_inc) begin
        r_beat <= r_beat + IDX_W'(1);
      end
      // Counters saturate at all-ones rather than wrapping.
      if (w_miss_inc && (r_miss_cnt != '1)) begin
        r_miss_cnt <= r_miss_cnt + CNT_W'(1);
      end
      if (w_wb_inc && (r_wb_cnt != '1)) begin
        r_wb_cnt <= r_wb_cnt + CNT_W'(1);
      end
    end
  end

  assign word_idx_o = r_beat;
  assign miss_cnt_o = r_miss_cnt;
  assign wb_cnt_o   = r_wb_cnt;

endmodule

// File: tb/tb_cache_burst_controller.sv
// tb_cache_burst_controller
//   Self-checking bench. It uses two instances:
//     u_a : WORDS_PER_LINE=4, CNT_W=16 (main behaviour, table + sequences)
//     u_b : WORDS_PER_LINE=1, CNT_W=2  (single-beat bursts, counter saturation)
//   Expected outputs are packed as
//   {stall, mem_req, mem_we, idx[1:0], data_we, fill_sel, tag_we, dirty_set, dirty_clr}.
//   Inputs are packed as {rd, wr, hit, dirty, ack}.
module tb_cache_burst_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A signals
  logic        a_rd = 1'b0, a_wr = 1'b0, a_hit = 1'b0, a_dirty = 1'b0, a_ack = 1'b0;
  logic        a_stall, a_req, a_we, a_dwe, a_fsel, a_twe, a_dset, a_dclr;
  logic [1:0]  a_idx;
  logic [15:0] a_miss, a_wb;

  // Instance B signals
  logic        b_rd = 1'b0, b_wr = 1'b0, b_hit = 1'b0, b_dirty = 1'b0, b_ack = 1'b0;
  logic        b_stall, b_req, b_we, b_dwe, b_fsel, b_twe, b_dset, b_dclr;
  logic [0:0]  b_idx;
  logic [1:0]  b_miss, b_wb;

  cache_burst_controller #(.WORDS_PER_LINE(4), .CNT_W(16)) u_a (
    .clk_i(clk), .rst_i(rst), .rd_i(a_rd), .wr_i(a_wr), .hit_i(a_hit),
    .dirty_i(a_dirty), .mem_ack_i(a_ack), .stall_o(a_stall), .mem_req_o(a_req),
    .mem_we_o(a_we), .word_idx_o(a_idx), .data_we_o(a_dwe), .fill_sel_o(a_fsel),
    .tag_we_o(a_twe), .dirty_set_o(a_dset), .dirty_clr_o(a_dclr),
    .miss_cnt_o(a_miss), .wb_cnt_o(a_wb)
  );

  cache_burst_controller #(.WORDS_PER_LINE(1), .CNT_W(2)) u_b (
    .clk_i(clk), .rst_i(rst), .rd_i(b_rd), .wr_i(b_wr), .hit_i(b_hit),
    .dirty_i(b_dirty), .mem_ack_i(b_ack), .stall_o(b_stall), .mem_req_o(b_req),
    .mem_we_o(b_we), .word_idx_o(b_idx), .data_we_o(b_dwe), .fill_sel_o(b_fsel),
    .tag_we_o(b_twe), .dirty_set_o(b_dset), .dirty_clr_o(b_dclr),
    .miss_cnt_o(b_miss), .wb_cnt_o(b_wb)
  );

  logic [9:0] w_out_a, w_out_b;
  assign w_out_a = {a_stall, a_req, a_we, a_idx, a_dwe, a_fsel, a_twe, a_dset, a_dclr};
  assign w_out_b = {b_stall, b_req, b_we, 1'b0, b_idx, b_dwe, b_fsel, b_twe, b_dset, b_dclr};

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic [9:0] mk(input logic stall, input logic req, input logic we,
                                    input logic [1:0] idx, input logic dwe, input logic fsel,
                                    input logic twe, input logic dset, input logic dclr);
    return {stall, req, we, idx, dwe, fsel, twe, dset, dclr};
  endfunction

  // One clock cycle: drive inputs just after the edge, compare mid-cycle.
  task automatic step(input bit dut_b, input string name, input logic [4:0] in,
                      input logic [9:0] exp);
    if (!dut_b) {a_rd, a_wr, a_hit, a_dirty, a_ack} = in;
    else        {b_rd, b_wr, b_hit, b_dirty, b_ack} = in;
    @(negedge clk);
    check(name, 32'(dut_b ? w_out_b : w_out_a), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [4:0] in;
    logic [9:0] exp;
  } vec_t;

  vec_t tbl[17];

  initial begin
    // Load hit, store hit, rd&wr treated as store, clean miss with ack every
    // cycle, then an ack in IDLE that must be ignored.
    tbl[0]  = '{5'b10100, mk(1,0,0,2'd0,0,0,0,0,0)};
    tbl[1]  = '{5'b10100, mk(0,0,0,2'd0,0,0,0,0,0)};
    tbl[2]  = '{5'b00000, mk(0,0,0,2'd0,0,0,0,0,0)};
    tbl[3]  = '{5'b01100, mk(1,0,0,2'd0,0,0,0,0,0)};
    tbl[4]  = '{5'b01100, mk(0,0,0,2'd0,1,0,0,1,0)};
    tbl[5]  = '{5'b00000, mk(0,0,0,2'd0,0,0,0,0,0)};
    tbl[6]  = '{5'b11100, mk(1,0,0,2'd0,0,0,0,0,0)};
    tbl[7]  = '{5'b11100, mk(0,0,0,2'd0,1,0,0,1,0)};
    tbl[8]  = '{5'b10000, mk(1,0,0,2'd0,0,0,0,0,0)};
    tbl[9]  = '{5'b10000, mk(1,0,0,2'd0,0,0,0,0,0)};
    tbl[10] = '{5'b10001, mk(1,1,0,2'd0,1,1,0,0,0)};
    tbl[11] = '{5'b10001, mk(1,1,0,2'd1,1,1,0,0,0)};
    tbl[12] = '{5'b10001, mk(1,1,0,2'd2,1,1,0,0,0)};
    tbl[13] = '{5'b10001, mk(1,1,0,2'd3,1,1,0,0,0)};
    tbl[14] = '{5'b10000, mk(1,0,0,2'd0,0,0,1,0,1)};
    tbl[15] = '{5'b10100, mk(0,0,0,2'd0,0,0,0,0,0)};
    tbl[16] = '{5'b00001, mk(0,0,0,2'd0,0,0,0,0,0)};

    // Synchronous reset for two edges.
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_outputs", 32'(w_out_a), 32'(0));
    check("reset_miss_cnt", 32'(a_miss), 32'(0));
    check("reset_wb_cnt", 32'(a_wb), 32'(0));
    @(posedge clk);
    #1;

    for (int i = 0; i < 17; i++) begin
      step(1'b0, $sformatf("vec%0d", i), tbl[i].in, tbl[i].exp);
    end
    check("clean_miss_cnt", 32'(a_miss), 32'(1));
    check("clean_wb_cnt", 32'(a_wb), 32'(0));

    // Dirty store miss, memory acks every third cycle.
    step(1'b0, "dm_idle", 5'b01010, mk(1,0,0,2'd0,0,0,0,0,0));
    step(1'b0, "dm_lookup", 5'b01010, mk(1,0,0,2'd0,0,0,0,0,0));
    for (int b = 0; b < 4; b++) begin
      for (int w = 0; w < 3; w++) begin
        step(1'b0, $sformatf("dm_wb_b%0d_w%0d", b, w), {4'b0101, 1'(w == 2)},
             mk(1,1,1,2'(b),0,0,0,0,0));
      end
    end
    for (int b = 0; b < 4; b++) begin
      for (int w = 0; w < 3; w++) begin
        step(1'b0, $sformatf("dm_fill_b%0d_w%0d", b, w), {4'b0101, 1'(w == 2)},
             mk(1,1,0,2'(b),1'(w == 2),1'(w == 2),0,0,0));
      end
    end
    step(1'b0, "dm_update", 5'b01010, mk(1,0,0,2'd0,0,0,1,0,1));
    step(1'b0, "dm_replay", 5'b01110, mk(0,0,0,2'd0,1,0,0,1,0));
    step(1'b0, "dm_idle_after", 5'b00000, mk(0,0,0,2'd0,0,0,0,0,0));
    check("dirty_miss_cnt", 32'(a_miss), 32'(2));
    check("dirty_wb_cnt", 32'(a_wb), 32'(1));

    // Reset in the middle of a refill, after two beats.
    step(1'b0, "rf_idle", 5'b10000, mk(1,0,0,2'd0,0,0,0,0,0));
    step(1'b0, "rf_lookup", 5'b10000, mk(1,0,0,2'd0,0,0,0,0,0));
    step(1'b0, "rf_beat0", 5'b10001, mk(1,1,0,2'd0,1,1,0,0,0));
    step(1'b0, "rf_beat1", 5'b10001, mk(1,1,0,2'd1,1,1,0,0,0));
    {a_rd, a_wr, a_hit, a_dirty, a_ack} = 5'b10000;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rf_miss_cnt_cleared", 32'(a_miss), 32'(0));
    check("rf_wb_cnt_cleared", 32'(a_wb), 32'(0));
    step(1'b0, "rf_late_ack0", 5'b00001, mk(0,0,0,2'd0,0,0,0,0,0));
    step(1'b0, "rf_late_ack1", 5'b00001, mk(0,0,0,2'd0,0,0,0,0,0));
    step(1'b0, "rf_new_req", 5'b10100, mk(1,0,0,2'd0,0,0,0,0,0));
    step(1'b0, "rf_new_hit", 5'b10100, mk(0,0,0,2'd0,0,0,0,0,0));
    check("rf_miss_cnt_after", 32'(a_miss), 32'(0));

    // Single-word lines, two-bit counters: five dirty misses saturate both.
    for (int k = 1; k <= 5; k++) begin
      step(1'b1, $sformatf("sat%0d_idle", k),   5'b10010, mk(1,0,0,2'd0,0,0,0,0,0));
      step(1'b1, $sformatf("sat%0d_lookup", k), 5'b10010, mk(1,0,0,2'd0,0,0,0,0,0));
      step(1'b1, $sformatf("sat%0d_wb", k),     5'b10011, mk(1,1,1,2'd0,0,0,0,0,0));
      step(1'b1, $sformatf("sat%0d_fill", k),   5'b10011, mk(1,1,0,2'd0,1,1,0,0,0));
      step(1'b1, $sformatf("sat%0d_update", k), 5'b10010, mk(1,0,0,2'd0,0,0,1,0,1));
      step(1'b1, $sformatf("sat%0d_replay", k), 5'b10110, mk(0,0,0,2'd0,0,0,0,0,0));
      check($sformatf("sat%0d_miss_cnt", k), 32'(b_miss), (k < 3) ? 32'(k) : 32'(3));
      check($sformatf("sat%0d_wb_cnt", k), 32'(b_wb), (k < 3) ? 32'(k) : 32'(3));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
